// File: rtl/stream_wr_burst.sv
// Stream-to-frame-buffer writer: FWFT FIFO feeding a burst write engine.
// Optional macro STREAM_WR_BURST_STATS_EN builds the completed-burst counter.
module stream_wr_burst #(
    parameter int MEM_DATA_BITS = 512,
    parameter int ADDR_BITS     = 28,
    parameter int BURST_LEN     = 64,
    parameter int FIFO_DEPTH    = 256,
    parameter int BASE_ADDR     = 0,
    parameter int FRAME_WORDS   = 4096
) (
    input  logic                        mem_clk,
    input  logic                        rst_n,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [MEM_DATA_BITS-1:0]    s_data,
    input  logic                        s_last,
    output logic                        wr_burst_req,
    output logic [9:0]                  wr_burst_len,
    output logic [ADDR_BITS-1:0]        wr_burst_addr,
    input  logic                        wr_burst_data_req,
    output logic [MEM_DATA_BITS-1:0]    wr_burst_data,
    input  logic                        wr_burst_finish,
    output logic                        frame_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [31:0]                 burst_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0]        DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0]        BLEN_L  = LW'(BURST_LEN);
    localparam logic [ADDR_BITS-1:0] BASE_L  = ADDR_BITS'(BASE_ADDR);
    localparam logic [ADDR_BITS:0]   LIMIT_L = (ADDR_BITS+1)'(BASE_ADDR + FRAME_WORDS * 8);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_FIN} state_t;
    state_t state, state_nxt;

    // ---------------- FIFO ----------------
    logic [MEM_DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic                     push, pop;

    assign s_ready       = rst_n && (fifo_level < DEPTH_L);
    assign push          = s_valid && s_ready;
    assign pop           = wr_burst_data_req && (fifo_level != '0);
    assign wr_burst_data = mem[rd_ptr];

    always_ff @(posedge mem_clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_level <= fifo_level + 1'b1;
            else if (pop && !push) fifo_level <= fifo_level - 1'b1;
        end
    end

    // ---------------- frame-end tracking ----------------
    // rem counts words from the FIFO head up to and including the s_last word.
    logic          flush, last_in_burst, frame_end, burst_fin;
    logic [LW-1:0] rem;

    assign burst_fin = (state == REQ) && wr_burst_finish;
    assign frame_end = burst_fin && last_in_burst;

    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            flush <= 1'b0;
            rem   <= '0;
        end else if (push && s_last && (!flush || frame_end)) begin
            flush <= 1'b1;
            rem   <= fifo_level + 1'b1 - {{(LW-1){1'b0}}, pop};
        end else begin
            if (frame_end)          flush <= 1'b0;
            if (pop && rem != '0)   rem   <= rem - 1'b1;
        end
    end

    // ---------------- burst FSM ----------------
    logic       part_go, full_go, launch;
    logic [9:0] len_nxt;

    // A partial burst takes only the words up to the marker, never what follows.
    assign part_go = flush && (rem != '0) && (rem < BLEN_L);
    assign full_go = fifo_level >= BLEN_L;

    always_ff @(posedge mem_clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (part_go || full_go) state_nxt = REQ;
            REQ:      if (wr_burst_finish)    state_nxt = WAIT_FIN;
            WAIT_FIN: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_burst_req = (state == REQ);
        launch       = (state == IDLE) && (state_nxt == REQ);
        len_nxt      = part_go ? 10'(rem) : 10'(BURST_LEN);
    end

    // ---------------- burst address / length ----------------
    logic [ADDR_BITS-1:0] next_addr;
    logic [ADDR_BITS:0]   addr_sum;

    assign addr_sum = {1'b0, wr_burst_addr} + (ADDR_BITS+1)'({wr_burst_len, 3'b000});

    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            wr_burst_len  <= '0;
            wr_burst_addr <= BASE_L;
            next_addr     <= BASE_L;
            last_in_burst <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (launch) begin
                wr_burst_len  <= len_nxt;
                wr_burst_addr <= next_addr;
                last_in_burst <= flush && (rem != '0) && (rem <= BLEN_L);
            end
            if (burst_fin) begin
                if (last_in_burst || addr_sum >= LIMIT_L) next_addr <= BASE_L;
                else                                      next_addr <= addr_sum[ADDR_BITS-1:0];
            end
        end
    end

`ifdef STREAM_WR_BURST_STATS_EN
    always_ff @(posedge mem_clk) begin
        if (!rst_n)         burst_cnt <= '0;
        else if (burst_fin) burst_cnt <= burst_cnt + 1'b1;
    end
`else
    assign burst_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_wr_burst.sv
// Directed bench for stream_wr_burst (FRAME_WORDS=128 so address wrap is reachable).
module tb_stream_wr_burst;
    logic         mem_clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s_valid = 1'b0, s_last = 1'b0;
    logic         s_ready;
    logic [511:0] s_data = '0;
    logic         wr_burst_req;
    logic [9:0]   wr_burst_len;
    logic [27:0]  wr_burst_addr;
    logic         wr_burst_data_req = 1'b0, wr_burst_finish = 1'b0;
    logic [511:0] wr_burst_data;
    logic         frame_done;
    logic [8:0]   fifo_level;
    logic [31:0]  burst_cnt;

    int n_chk = 0, n_pass = 0, fd_cnt = 0, fd_base;
    int exp_cnt;

    stream_wr_burst #(.FRAME_WORDS(128)) dut (
        .mem_clk(mem_clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
        .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
        .wr_burst_finish(wr_burst_finish), .frame_done(frame_done),
        .fifo_level(fifo_level), .burst_cnt(burst_cnt)
    );

    always #5 mem_clk = ~mem_clk;

    always @(posedge mem_clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge mem_clk);
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
        repeat (2) @(negedge mem_clk);
        rst_n = 1'b1;
        @(negedge mem_clk);
    endtask

    // Called at a negedge; returns at the negedge after the final word is accepted.
    task automatic push_words(input int first, input int n, input bit last_on_end);
        int t;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = {8{64'(first + i)}};
            s_last  = last_on_end && (i == n - 1);
            t = 0;
            while (!s_ready && t < 3000) begin @(negedge mem_clk); t++; end
            if (!s_ready) begin
                chk("push_timeout", 64'd0, 64'd1);
                s_valid = 1'b0; s_last = 1'b0;
                return;
            end
            @(negedge mem_clk);
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    // Burst-engine model: wait for a request, pop len words, pulse finish.
    task automatic serve(input string tag, input int exp_len, input int exp_addr, input int first_id);
        int t, errs;
        t = 0;
        while (wr_burst_req !== 1'b1 && t < 3000) begin @(negedge mem_clk); t++; end
        chk({tag, "_req"}, 64'(wr_burst_req), 64'd1);
        if (wr_burst_req !== 1'b1) return;
        chk({tag, "_len"}, 64'(wr_burst_len), 64'(exp_len));
        chk({tag, "_addr"}, 64'(wr_burst_addr), 64'(exp_addr));
        errs = 0;
        for (int i = 0; i < exp_len; i++) begin
            if (wr_burst_data[63:0] !== 64'(first_id + i)) errs++;
            wr_burst_data_req = 1'b1;
            @(negedge mem_clk);
        end
        chk({tag, "_data_errs"}, 64'(errs), 64'd0);
        wr_burst_data_req = 1'b0;
        wr_burst_finish   = 1'b1;
        @(negedge mem_clk);
        wr_burst_finish = 1'b0;
        chk({tag, "_req_drop"}, 64'(wr_burst_req), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge mem_clk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_req", 64'(wr_burst_req), 64'd0);
        chk("rst_len", 64'(wr_burst_len), 64'd0);
        chk("rst_addr", 64'(wr_burst_addr), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_burst_cnt", 64'(burst_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge mem_clk);

        // Full bursts, latency, and frame-buffer wrap (0, 512, 0)
        push_words(0, 64, 1'b0);
        chk("lat_n1", 64'(wr_burst_req), 64'd0);
        @(negedge mem_clk);
        chk("lat_n2", 64'(wr_burst_req), 64'd1);
        serve("b0", 64, 0, 0);
        push_words(64, 64, 1'b0);
        serve("b1", 64, 512, 64);
        push_words(128, 64, 1'b0);
        serve("b2_wrap", 64, 0, 128);
        chk("b_level_empty", 64'(fifo_level), 64'd0);

        // Frame with s_last on word 99: 64 + 36, then restart at base
        do_reset();
        fd_base = fd_cnt;
        push_words(1000, 100, 1'b1);
        serve("f0", 64, 0, 1000);
        chk("f0_no_frame_done", 64'(frame_done), 64'd0);
        serve("f1", 36, 512, 1064);
        chk("f1_frame_done_hi", 64'(frame_done), 64'd1);
        @(negedge mem_clk);
        chk("f1_frame_done_lo", 64'(frame_done), 64'd0);
        push_words(1100, 64, 1'b0);
        serve("f2", 64, 0, 1100);
        chk("frame_done_count", 64'(fd_cnt - fd_base), 64'd1);

        // Backpressure: fill 256, word 257 waits, then drains in order
        do_reset();
        push_words(2000, 256, 1'b0);
        chk("full_level", 64'(fifo_level), 64'd256);
        chk("full_s_ready", 64'(s_ready), 64'd0);
        fork
            push_words(2256, 1, 1'b0);
            begin
                repeat (3) @(negedge mem_clk);
                chk("held_level", 64'(fifo_level), 64'd256);
                chk("held_s_ready", 64'(s_ready), 64'd0);
                serve("d0", 64, 0, 2000);
                serve("d1", 64, 512, 2064);
                serve("d2", 64, 0, 2128);
                serve("d3", 64, 512, 2192);
            end
        join
        chk("held_word_level", 64'(fifo_level), 64'd1);
        chk("held_word_head", wr_burst_data[63:0], 64'd2256);
        push_words(2257, 63, 1'b0);
        serve("d4", 64, 0, 2256);
`ifdef STREAM_WR_BURST_STATS_EN
        exp_cnt = 5;
`else
        exp_cnt = 0;
`endif
        chk("burst_cnt", 64'(burst_cnt), 64'(exp_cnt));

        // Reset in the middle of a burst data phase
        do_reset();
        push_words(4000, 128, 1'b0);
        serve("r0", 64, 0, 4000);
        begin
            int t = 0;
            while (wr_burst_req !== 1'b1 && t < 3000) begin @(negedge mem_clk); t++; end
        end
        chk("r1_addr", 64'(wr_burst_addr), 64'd512);
        repeat (10) begin
            wr_burst_data_req = 1'b1;
            @(negedge mem_clk);
        end
        chk("r1_mid_level", 64'(fifo_level), 64'd54);
        rst_n = 1'b0;
        wr_burst_data_req = 1'b0;
        @(negedge mem_clk);
        chk("rr_req", 64'(wr_burst_req), 64'd0);
        chk("rr_level", 64'(fifo_level), 64'd0);
        chk("rr_addr", 64'(wr_burst_addr), 64'd0);
        chk("rr_s_ready", 64'(s_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge mem_clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/stream_wr_burst.md
STREAM_WR_BURST -- requirements
Module: stream_wr_burst

Interface
REQ-001 SHALL have parameter MEM_DATA_BITS, default 512: width of one memory word.
REQ-002 SHALL have parameter ADDR_BITS, default 28: width of the burst address.
REQ-003 SHALL have parameter BURST_LEN, default 64: number of words in a full burst, range 1..512.
REQ-004 SHALL have parameter FIFO_DEPTH, default 256: number of FIFO entries, a power of 2, at least 2*BURST_LEN.
REQ-005 SHALL have parameter BASE_ADDR, default 0: start address of the frame buffer.
REQ-006 SHALL have parameter FRAME_WORDS, default 4096: size of the frame buffer in words.
REQ-007 SHALL have port mem_clk, input, width 1: the only clock.
REQ-008 SHALL have port rst_n, input, width 1: reset, synchronous, active-low.
REQ-009 SHALL have port s_valid, input, width 1: stream word valid.
REQ-010 SHALL have port s_ready, output, width 1: stream word accepted.
REQ-011 SHALL have port s_data, input, width MEM_DATA_BITS: stream word.
REQ-012 SHALL have port s_last, input, width 1: last word of the frame.
REQ-013 SHALL have port wr_burst_req, output, width 1: write burst request.
REQ-014 SHALL have port wr_burst_len, output, width 10: number of words in the burst.
REQ-015 SHALL have port wr_burst_addr, output, width ADDR_BITS: burst start address.
REQ-016 SHALL have port wr_burst_data_req, input, width 1: the burst engine pops one word.
REQ-017 SHALL have port wr_burst_data, output, width MEM_DATA_BITS: the word at the FIFO head.
REQ-018 SHALL have port wr_burst_finish, input, width 1: one-cycle pulse marking burst completion.
REQ-019 SHALL have port frame_done, output, width 1: one-cycle pulse when the last burst of a frame finishes.
REQ-020 SHALL have port fifo_level, output, width log2(FIFO_DEPTH)+1: current FIFO occupancy.
REQ-021 SHALL have port burst_cnt, output, width 32: count of completed bursts.

Function
REQ-022 SHALL implement a first-word-fall-through FIFO, so wr_burst_data always equals the FIFO head word.
REQ-023 SHALL drive s_ready = (fifo_level < FIFO_DEPTH) and push the word when s_valid && s_ready are both high.
REQ-024 SHALL pop one word each cycle wr_burst_data_req is high; a push and a pop in the same cycle SHALL leave fifo_level unchanged.
REQ-025 SHALL latch an internal flush flag on an accepted word with s_last=1, and SHALL record the FIFO position of that word.
REQ-026 SHALL implement the FSM states IDLE, REQ and WAIT_FIN.
REQ-027 IDLE->REQ SHALL occur when fifo_level >= BURST_LEN (full burst, len=BURST_LEN).
REQ-027a IDLE->REQ SHALL occur when flush is set and 0 < words-before-last-marker < BURST_LEN (partial burst, len = those words).
REQ-028 SHALL register wr_burst_len and wr_burst_addr on the IDLE->REQ transition and hold them until the next burst.
REQ-029 In REQ, SHALL hold wr_burst_req high until the wr_burst_finish cycle, then drop it on the next cycle.
REQ-030 REQ->WAIT_FIN SHALL occur on wr_burst_finish.
REQ-030a WAIT_FIN SHALL last one cycle, then go to IDLE.
REQ-031 After each burst, SHALL add len*8 to the address; each word occupies 8 address units.
REQ-032 If the next address >= BASE_ADDR+FRAME_WORDS*8, SHALL set the address to BASE_ADDR (wrap).
REQ-033 When the burst that contains the s_last word finishes, SHALL pulse frame_done for 1 cycle, reset the address to BASE_ADDR and clear flush.
REQ-034 Words beyond the s_last marker SHALL belong to the next frame; they SHALL never be merged into the partial burst.
REQ-035 A pop while the FIFO is empty SHALL be ignored; fifo_level SHALL never underflow.
REQ-036 Minimum latency: the 64th word accepted at cycle N -> wr_burst_req high at N+2.

Reset
REQ-037 With rst_n=0 at a mem_clk edge, SHALL reset:
- FIFO emptied, fifo_level=0, s_ready=0 during reset;
- FSM=IDLE, wr_burst_req=0, wr_burst_len=0, wr_burst_addr=BASE_ADDR;
- flush=0, frame_done=0, burst_cnt=0.
REQ-038 A reset mid-burst SHALL abort the burst at once; the burst engine is reset in the same domain.

Configuration
REQ-039 Macro STREAM_WR_BURST_STATS_EN:
- defined: burst_cnt SHALL increment by 1 on every wr_burst_finish seen in REQ, wrapping at 2^32;
- undefined: burst_cnt SHALL be tied to 0 and no counter logic SHALL be built.

Verification
REQ-040 Push 64 words (0..63), no s_last -> one burst, len=64, addr=0; data pops 0..63 in order; the next burst has addr=512.
REQ-041 Push 100 words, s_last on word 99 -> bursts of len=64 at addr=0 and len=36 at addr=512; frame_done pulses once; the next burst starts at addr=0.
REQ-042 Hold wr_burst_data_req=0 and push 256 words -> s_ready=0 at fifo_level=256; word 257 is held, not lost.
REQ-043 With FRAME_WORDS=128 and 192 words pushed without s_last -> burst addresses are 0, 512, 0.
REQ-044 Assert rst_n=0 in the middle of the data phase -> next cycle: wr_burst_req=0, fifo_level=0, wr_burst_addr=0.
REQ-045 With the macro defined, run 5 bursts -> burst_cnt=5; with it undefined -> burst_cnt=0.
